// File: rtl/msrh_l1d_rd_arbiter_pkg.sv
// rtl/msrh_l1d_rd_arbiter_pkg.sv - L1D read-port arbiter shared types and widths
package msrh_l1d_rd_arbiter_pkg;

    localparam int PADDR_W       = 56;
    localparam int DCACHE_DATA_W = 64;
    localparam int DCACHE_WAYS   = 4;
    localparam int DCACHE_WAY_W  = $clog2(DCACHE_WAYS);

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic               h_pri;
    } l1d_rd_req_t;

    typedef struct packed {
        logic                     hit;
        logic                     miss;
        logic                     conflict;
        logic [DCACHE_DATA_W-1:0] data;
        logic                     replace_valid;
        logic [DCACHE_WAY_W-1:0]  replace_way;
        logic [DCACHE_DATA_W-1:0] replace_data;
        logic [PADDR_W-1:0]       replace_paddr;
    } l1d_rd_resp_t;

endpackage

// File: rtl/msrh_l1d_rd_arbiter_rr_pick_oh.sv
// rtl/msrh_l1d_rd_arbiter_rr_pick_oh.sv - round-robin one-hot picker scanning upward from ptr with wrap
module msrh_rr_pick_oh #(
    parameter int N     = 3,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_oh
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] masked;
    logic [N-1:0] src;
    logic         found;

    // Requests at or above ptr take precedence; otherwise the scan wraps to index 0.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (IDX_W'(i) >= ptr);
        end
        masked = req & hi_mask;
        src    = (|masked) ? masked : req;
    end

    always_comb begin
        grant_oh = '0;
        found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (src[i] && !found) begin
                grant_oh[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msrh_l1d_rd_arbiter.sv
// rtl/msrh_l1d_rd_arbiter.sv - shares the L1D read port: h_pri, starvation, round-robin grant with s1 routing
module msrh_l1d_rd_arbiter
    import msrh_l1d_rd_arbiter_pkg::*;
#(
    parameter int REQ_N      = 3,
    parameter int STARVE_MAX = 7,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset_n,

    input  logic [REQ_N-1:0]                     i_req_valid,
    input  logic [REQ_N-1:0][PADDR_W-1:0]        i_req_paddr,
    input  logic [REQ_N-1:0]                     i_req_h_pri,
    output logic [REQ_N-1:0]                     o_req_ready,

    output logic [REQ_N-1:0]                     o_resp_valid,
    output logic                                 o_resp_hit,
    output logic                                 o_resp_miss,
    output logic                                 o_resp_conflict,
    output logic [DCACHE_DATA_W-1:0]             o_resp_data,
    output logic                                 o_resp_replace_valid,
    output logic [DCACHE_WAY_W-1:0]              o_resp_replace_way,
    output logic [DCACHE_DATA_W-1:0]             o_resp_replace_data,
    output logic [PADDR_W-1:0]                   o_resp_replace_paddr,

    output logic                                 o_l1d_s0_valid,
    output logic [PADDR_W-1:0]                   o_l1d_s0_paddr,
    output logic                                 o_l1d_s0_h_pri,

    input  logic                                 i_l1d_s1_hit,
    input  logic                                 i_l1d_s1_miss,
    input  logic                                 i_l1d_s1_conflict,
    input  logic [DCACHE_DATA_W-1:0]             i_l1d_s1_data,
    input  logic                                 i_l1d_s1_replace_valid,
    input  logic [DCACHE_WAY_W-1:0]              i_l1d_s1_replace_way,
    input  logic [DCACHE_DATA_W-1:0]             i_l1d_s1_replace_data,
    input  logic [PADDR_W-1:0]                   i_l1d_s1_replace_paddr
);

    localparam int IDX_W = $clog2(REQ_N);

    logic [IDX_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0] r_starve_cnt [REQ_N];
    logic             r_s1_valid;
    logic [IDX_W-1:0] r_s1_idx;

    logic [REQ_N-1:0] hpri_req;
    logic [REQ_N-1:0] starve_req;
    logic [REQ_N-1:0] hpri_oh;
    logic [REQ_N-1:0] starve_oh;
    logic [REQ_N-1:0] rr_oh;
    logic [REQ_N-1:0] grant_oh;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    logic             hpri_found;
    logic             starve_found;

    l1d_rd_req_t      req_arr [REQ_N];
    l1d_rd_req_t      s0_req;
    l1d_rd_resp_t     s1_resp;

    always_comb begin
        for (int i = 0; i < REQ_N; i++) begin
            req_arr[i].paddr = i_req_paddr[i];
            req_arr[i].h_pri = i_req_h_pri[i];
        end
    end

    // Tier candidates: lowest index wins within the h_pri and starved tiers.
    always_comb begin
        hpri_req     = i_req_valid & i_req_h_pri;
        starve_req   = '0;
        hpri_oh      = '0;
        starve_oh    = '0;
        hpri_found   = 1'b0;
        starve_found = 1'b0;
        for (int i = 0; i < REQ_N; i++) begin
            starve_req[i] = i_req_valid[i] && (r_starve_cnt[i] == CNT_W'(STARVE_MAX));
        end
        for (int i = 0; i < REQ_N; i++) begin
            if (hpri_req[i] && !hpri_found) begin
                hpri_oh[i] = 1'b1;
                hpri_found = 1'b1;
            end
            if (starve_req[i] && !starve_found) begin
                starve_oh[i] = 1'b1;
                starve_found = 1'b1;
            end
        end
    end

    msrh_rr_pick_oh #(
        .N     (REQ_N),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (i_req_valid),
        .ptr      (r_rr_ptr),
        .grant_oh (rr_oh)
    );

    always_comb begin
        if (|hpri_req) begin
            grant_oh = hpri_oh;
        end else if (|starve_req) begin
            grant_oh = starve_oh;
        end else begin
            grant_oh = rr_oh;
        end
    end

    always_comb begin
        grant_idx = '0;
        s0_req    = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (grant_oh[i]) begin
                grant_idx = IDX_W'(i);
                s0_req    = req_arr[i];
            end
        end
    end

    assign grant_any      = |grant_oh;
    assign o_req_ready    = grant_oh;
    assign o_l1d_s0_valid = grant_any;
    assign o_l1d_s0_paddr = s0_req.paddr;
    assign o_l1d_s0_h_pri = s0_req.h_pri;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rr_ptr <= '0;
        end else if (grant_any) begin
            r_rr_ptr <= (grant_idx == IDX_W'(REQ_N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Denied requesters age toward the starved tier; a grant or a dropped request clears the age.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < REQ_N; i++) begin
                r_starve_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQ_N; i++) begin
                if (i_req_valid[i] && !grant_oh[i]) begin
                    if (r_starve_cnt[i] != CNT_W'(STARVE_MAX)) begin
                        r_starve_cnt[i] <= r_starve_cnt[i] + 1'b1;
                    end
                end else begin
                    r_starve_cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= grant_any;
            r_s1_idx   <= grant_idx;
        end
    end

    always_comb begin
        for (int i = 0; i < REQ_N; i++) begin
            o_resp_valid[i] = r_s1_valid && (r_s1_idx == IDX_W'(i));
        end
    end

    // Slave results are broadcast untouched; consumers qualify them with o_resp_valid.
    always_comb begin
        s1_resp.hit           = i_l1d_s1_hit;
        s1_resp.miss          = i_l1d_s1_miss;
        s1_resp.conflict      = i_l1d_s1_conflict;
        s1_resp.data          = i_l1d_s1_data;
        s1_resp.replace_valid = i_l1d_s1_replace_valid;
        s1_resp.replace_way   = i_l1d_s1_replace_way;
        s1_resp.replace_data  = i_l1d_s1_replace_data;
        s1_resp.replace_paddr = i_l1d_s1_replace_paddr;
    end

    assign o_resp_hit           = s1_resp.hit;
    assign o_resp_miss          = s1_resp.miss;
    assign o_resp_conflict      = s1_resp.conflict;
    assign o_resp_data          = s1_resp.data;
    assign o_resp_replace_valid = s1_resp.replace_valid;
    assign o_resp_replace_way   = s1_resp.replace_way;
    assign o_resp_replace_data  = s1_resp.replace_data;
    assign o_resp_replace_paddr = s1_resp.replace_paddr;

    a_ready_onehot0: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(o_req_ready));
    a_resp_onehot0: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        $onehot0(o_resp_valid));
    a_no_grant_without_valid: assert property (@(posedge i_clk) disable iff (!i_reset_n)
        (o_req_ready & ~i_req_valid) == '0);

endmodule

// File: tb/tb_msrh_l1d_rd_arbiter.sv
// tb/tb_msrh_l1d_rd_arbiter.sv - self-checking bench for msrh_l1d_rd_arbiter
module tb_msrh_l1d_rd_arbiter;
    import msrh_l1d_rd_arbiter_pkg::*;

    localparam int REQ_N      = 3;
    localparam int STARVE_MAX = 7;

    logic                          i_clk;
    logic                          i_reset_n;
    logic [REQ_N-1:0]              i_req_valid;
    logic [REQ_N-1:0][PADDR_W-1:0] i_req_paddr;
    logic [REQ_N-1:0]              i_req_h_pri;
    logic [REQ_N-1:0]              o_req_ready;
    logic [REQ_N-1:0]              o_resp_valid;
    logic                          o_resp_hit;
    logic                          o_resp_miss;
    logic                          o_resp_conflict;
    logic [DCACHE_DATA_W-1:0]      o_resp_data;
    logic                          o_resp_replace_valid;
    logic [DCACHE_WAY_W-1:0]       o_resp_replace_way;
    logic [DCACHE_DATA_W-1:0]      o_resp_replace_data;
    logic [PADDR_W-1:0]            o_resp_replace_paddr;
    logic                          o_l1d_s0_valid;
    logic [PADDR_W-1:0]            o_l1d_s0_paddr;
    logic                          o_l1d_s0_h_pri;
    logic                          i_l1d_s1_hit;
    logic                          i_l1d_s1_miss;
    logic                          i_l1d_s1_conflict;
    logic [DCACHE_DATA_W-1:0]      i_l1d_s1_data;
    logic                          i_l1d_s1_replace_valid;
    logic [DCACHE_WAY_W-1:0]       i_l1d_s1_replace_way;
    logic [DCACHE_DATA_W-1:0]      i_l1d_s1_replace_data;
    logic [PADDR_W-1:0]            i_l1d_s1_replace_paddr;

    int n_tests;
    int n_fail;

    int m_ptr;
    int m_cnt [REQ_N];
    int m_s1;

    msrh_l1d_rd_arbiter #(
        .REQ_N      (REQ_N),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .i_clk                  (i_clk),
        .i_reset_n              (i_reset_n),
        .i_req_valid            (i_req_valid),
        .i_req_paddr            (i_req_paddr),
        .i_req_h_pri            (i_req_h_pri),
        .o_req_ready            (o_req_ready),
        .o_resp_valid           (o_resp_valid),
        .o_resp_hit             (o_resp_hit),
        .o_resp_miss            (o_resp_miss),
        .o_resp_conflict        (o_resp_conflict),
        .o_resp_data            (o_resp_data),
        .o_resp_replace_valid   (o_resp_replace_valid),
        .o_resp_replace_way     (o_resp_replace_way),
        .o_resp_replace_data    (o_resp_replace_data),
        .o_resp_replace_paddr   (o_resp_replace_paddr),
        .o_l1d_s0_valid         (o_l1d_s0_valid),
        .o_l1d_s0_paddr         (o_l1d_s0_paddr),
        .o_l1d_s0_h_pri         (o_l1d_s0_h_pri),
        .i_l1d_s1_hit           (i_l1d_s1_hit),
        .i_l1d_s1_miss          (i_l1d_s1_miss),
        .i_l1d_s1_conflict      (i_l1d_s1_conflict),
        .i_l1d_s1_data          (i_l1d_s1_data),
        .i_l1d_s1_replace_valid (i_l1d_s1_replace_valid),
        .i_l1d_s1_replace_way   (i_l1d_s1_replace_way),
        .i_l1d_s1_replace_data  (i_l1d_s1_replace_data),
        .i_l1d_s1_replace_paddr (i_l1d_s1_replace_paddr)
    );

    always #5 i_clk = ~i_clk;

    // Reference: h_pri lowest index, then lowest starved index, then first valid scanning up from the pointer.
    function automatic int model_grant();
        for (int i = 0; i < REQ_N; i++)
            if (i_req_valid[i] && i_req_h_pri[i]) return i;
        for (int i = 0; i < REQ_N; i++)
            if (i_req_valid[i] && m_cnt[i] == STARVE_MAX) return i;
        for (int k = 0; k < REQ_N; k++) begin
            int j;
            j = (m_ptr + k) % REQ_N;
            for (int i = 0; i < REQ_N; i++)
                if (i == j && i_req_valid[i]) return j;
        end
        return -1;
    endfunction

    function automatic logic [REQ_N-1:0] onehot(input int g);
        logic [REQ_N-1:0] r;
        r = '0;
        for (int i = 0; i < REQ_N; i++)
            if (i == g) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [PADDR_W-1:0] paddr_of(input int g);
        logic [PADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < REQ_N; i++)
            if (i == g) r = i_req_paddr[i];
        return r;
    endfunction

    task automatic drive(input logic [REQ_N-1:0] v, input logic [REQ_N-1:0] h);
        i_req_valid = v;
        i_req_h_pri = h;
        for (int i = 0; i < REQ_N; i++)
            i_req_paddr[i] = PADDR_W'({$urandom(), $urandom()});
        i_l1d_s1_hit           = 1'($urandom_range(0, 1));
        i_l1d_s1_miss          = 1'($urandom_range(0, 1));
        i_l1d_s1_conflict      = 1'($urandom_range(0, 1));
        i_l1d_s1_data          = DCACHE_DATA_W'({$urandom(), $urandom()});
        i_l1d_s1_replace_valid = 1'($urandom_range(0, 1));
        i_l1d_s1_replace_way   = DCACHE_WAY_W'($urandom_range(0, DCACHE_WAYS - 1));
        i_l1d_s1_replace_data  = DCACHE_DATA_W'({$urandom(), $urandom()});
        i_l1d_s1_replace_paddr = PADDR_W'({$urandom(), $urandom()});
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_s1  = -1;
        for (int i = 0; i < REQ_N; i++) m_cnt[i] = 0;
    endtask

    task automatic tick();
        int g;
        g = model_grant();
        @(posedge i_clk);
        for (int i = 0; i < REQ_N; i++) begin
            if (i_req_valid[i] && i != g)
                m_cnt[i] = (m_cnt[i] < STARVE_MAX) ? m_cnt[i] + 1 : STARVE_MAX;
            else
                m_cnt[i] = 0;
        end
        if (g >= 0) m_ptr = (g + 1) % REQ_N;
        m_s1 = g;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0;
        drive('0, '0);
        model_reset();
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        drive('0, '0);
        model_reset();
        repeat (2) @(negedge i_clk);
        #1;
        n_tests++;
        if (o_resp_valid !== 3'b000) begin
            n_fail++; $display("FAIL reset_resp_valid got %b want 000", o_resp_valid);
        end
        n_tests++;
        if (o_req_ready !== 3'b000 || o_l1d_s0_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got %b/%b want 000/0", o_req_ready, o_l1d_s0_valid);
        end
        n_tests++;
        if (o_l1d_s0_paddr !== '0 || o_l1d_s0_h_pri !== 1'b0) begin
            n_fail++; $display("FAIL idle_s0_fields got %h/%b want 0/0", o_l1d_s0_paddr, o_l1d_s0_h_pri);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        drive(3'b010, 3'b000);
        i_req_paddr[1] = PADDR_W'(64'h8000_0040);
        #1;
        n_tests++;
        if (o_req_ready !== 3'b010) begin
            n_fail++; $display("FAIL single_ready got %b want 010", o_req_ready);
        end
        n_tests++;
        if (o_l1d_s0_paddr !== PADDR_W'(64'h8000_0040) || o_l1d_s0_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_s0_paddr got %h/%b want 80000040/1", o_l1d_s0_paddr, o_l1d_s0_valid);
        end
        tick();
        drive(3'b000, 3'b000);
        #1;
        n_tests++;
        if (o_resp_valid !== 3'b010) begin
            n_fail++; $display("FAIL single_resp_valid got %b want 010", o_resp_valid);
        end
        n_tests++;
        if (o_resp_data !== i_l1d_s1_data) begin
            n_fail++; $display("FAIL single_resp_data got %h want %h", o_resp_data, i_l1d_s1_data);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(3'b111, 3'b000);
            #1;
            n_tests++;
            if (o_req_ready !== onehot(c % 3)) begin
                n_fail++; $display("FAIL rr_seq[%0d] got %b want %b", c, o_req_ready, onehot(c % 3));
            end
            tick();
        end
    endtask

    task automatic test_h_pri();
        do_reset();
        drive(3'b101, 3'b100);
        #1;
        n_tests++;
        if (o_req_ready !== 3'b100 || o_l1d_s0_h_pri !== 1'b1) begin
            n_fail++; $display("FAIL hpri_grant got %b/%b want 100/1", o_req_ready, o_l1d_s0_h_pri);
        end
        tick();
        drive(3'b111, 3'b101);
        #1;
        n_tests++;
        if (o_req_ready !== 3'b001) begin
            n_fail++; $display("FAIL hpri_lowest got %b want 001", o_req_ready);
        end
        tick();
    endtask

    task automatic starve_run(input int n_hold, input logic [REQ_N-1:0] want);
        do_reset();
        drive(3'b010, 3'b000);
        tick();
        for (int c = 0; c < n_hold; c++) begin
            drive(3'b011, 3'b010);
            #1;
            n_tests++;
            if (o_req_ready !== 3'b010) begin
                n_fail++; $display("FAIL starve_hold[%0d] got %b want 010", c, o_req_ready);
            end
            tick();
        end
        drive(3'b111, 3'b000);
        #1;
        n_tests++;
        if (o_req_ready !== want) begin
            n_fail++; $display("FAIL starve_after_%0d got %b want %b", n_hold, o_req_ready, want);
        end
        tick();
    endtask

    task automatic test_starvation();
        starve_run(8, 3'b001);
        starve_run(6, 3'b100);
    endtask

    task automatic test_conflict();
        do_reset();
        drive(3'b001, 3'b000);
        tick();
        drive(3'b001, 3'b000);
        i_l1d_s1_conflict = 1'b1;
        i_l1d_s1_hit      = 1'b0;
        #1;
        n_tests++;
        if (o_resp_valid !== 3'b001 || o_resp_conflict !== 1'b1 || o_resp_hit !== 1'b0) begin
            n_fail++; $display("FAIL conflict_pass got %b/%b/%b want 001/1/0", o_resp_valid, o_resp_conflict, o_resp_hit);
        end
        n_tests++;
        if (o_req_ready !== 3'b001) begin
            n_fail++; $display("FAIL conflict_regrant got %b want 001", o_req_ready);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        drive(3'b010, 3'b000);
        tick();
        drive(3'b001, 3'b000);
        #1;
        n_tests++;
        if (o_req_ready !== 3'b001) begin
            n_fail++; $display("FAIL wrap_grant got %b want 001", o_req_ready);
        end
        tick();
        drive(3'b011, 3'b000);
        #1;
        n_tests++;
        if (o_req_ready !== 3'b010) begin
            n_fail++; $display("FAIL wrap_ptr_one got %b want 010", o_req_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(3'b110, 3'b010);
            tick();
        end
        drive(3'b000, 3'b000);
        #1;
        n_tests++;
        if (o_resp_valid !== 3'b010) begin
            n_fail++; $display("FAIL midrst_pre got %b want 010", o_resp_valid);
        end
        i_reset_n = 1'b0;
        #1;
        n_tests++;
        if (o_resp_valid !== 3'b000) begin
            n_fail++; $display("FAIL midrst_drop got %b want 000", o_resp_valid);
        end
        model_reset();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        drive(3'b101, 3'b000);
        #1;
        n_tests++;
        if (o_req_ready !== 3'b001) begin
            n_fail++; $display("FAIL midrst_cleared got %b want 001", o_req_ready);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            int g;
            logic [REQ_N-1:0] v;
            logic [REQ_N-1:0] h;
            v = REQ_N'($urandom_range(0, 7));
            h = REQ_N'($urandom_range(0, 7)) & REQ_N'($urandom_range(0, 7)) & REQ_N'($urandom_range(0, 7));
            drive(v, h);
            #1;
            g = model_grant();
            n_tests++;
            if (o_req_ready !== onehot(g)) begin
                n_fail++; $display("FAIL rand_ready[%0d] got %b want %b", c, o_req_ready, onehot(g));
            end
            n_tests++;
            if (o_l1d_s0_valid !== (g >= 0) || o_l1d_s0_paddr !== paddr_of(g)) begin
                n_fail++; $display("FAIL rand_s0[%0d] got %b/%h want %b/%h", c, o_l1d_s0_valid, o_l1d_s0_paddr, (g >= 0), paddr_of(g));
            end
            n_tests++;
            if (o_l1d_s0_h_pri !== ((g >= 0) && h[g % REQ_N])) begin
                n_fail++; $display("FAIL rand_s0_hpri[%0d] got %b", c, o_l1d_s0_h_pri);
            end
            n_tests++;
            if (o_resp_valid !== onehot(m_s1)) begin
                n_fail++; $display("FAIL rand_resp_valid[%0d] got %b want %b", c, o_resp_valid, onehot(m_s1));
            end
            n_tests++;
            if (o_resp_replace_paddr !== i_l1d_s1_replace_paddr || o_resp_replace_way !== i_l1d_s1_replace_way ||
                o_resp_miss !== i_l1d_s1_miss || o_resp_replace_data !== i_l1d_s1_replace_data) begin
                n_fail++; $display("FAIL rand_passthru[%0d] got %h/%h want %h/%h", c, o_resp_replace_paddr, o_resp_replace_way, i_l1d_s1_replace_paddr, i_l1d_s1_replace_way);
            end
            tick();
        end
    endtask

    initial begin
        i_clk     = 1'b0;
        i_reset_n = 1'b0;
        n_tests   = 0;
        n_fail    = 0;
        drive('0, '0);
        model_reset();
        @(negedge i_clk);
        test_reset();
        test_single();
        test_round_robin();
        test_h_pri();
        test_starvation();
        test_conflict();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
